sort_result_serializer: RTL and testbench
=========================================

Name: sort_result_serializer

Overview:
- Consumer of the bitonic sorter's output bus.
- Takes each packed N x DATA_W sorted word (out/valid_out) and buffers it in a small FIFO.
- Streams the elements one per beat over a valid/ready byte interface, with a last-element marker.
- Closes the loop from the parallel sorter result back to a serial stream for the UART/host side.

Parameters:
- N, 8, elements per packed word
- DATA_W, 8, bits per element
- DEPTH, 2, FIFO depth in words (power of two, >= 2)
- REVERSE, 0, 0 = emit element 0 first; 1 = emit element N-1 first

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_data  in  N*DATA_W  packed sorted word; element k is the k-th DATA_W slice from the MSB (element 0 = MSB slice)
- valid_in  in  1  in_data is valid this cycle (single-cycle pulse per word)
- in_ready  out  1  FIFO can accept a word this cycle
- m_data  out  DATA_W  current output element
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accepts m_data
- m_last  out  1  current element is the final one of its word
- overflow  out  1  sticky: a word arrived while the FIFO was full
- words_sent  out  16  count of fully transmitted words, wraps at 65535 -> 0

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO emptied; FSM to IDLE.
  - m_valid=0, m_last=0, m_data=0, overflow=0, words_sent=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-stream discards the partial word and all buffered words; no further beats of them appear.
- FIFO:
  - in_ready = (count < DEPTH), combinational from registered count.
  - Push on valid_in && in_ready.
  - valid_in && !in_ready: word dropped, overflow set to 1 and held until rst.
  - Push and pop in the same cycle both take effect, count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM, 2 states:
  - IDLE:
    - m_valid=0.
    - If FIFO non-empty: load head into shift register, pop, idx=0, go to SEND.
    - A word pushed into an empty FIFO at edge t is popped at edge t+1; m_valid=1 with element 0 after edge t+1. Word-in to first beat = 2 cycles.
  - SEND:
    - m_valid=1.
    - m_data = element idx; with REVERSE=1, element N-1-idx.
    - m_last = (idx == N-1).
    - m_valid && m_ready: idx++.
    - m_valid && !m_ready: m_data, m_last, idx held stable (AXI-style; no data change while stalled).
    - Beat with m_last && m_ready: words_sent++, then:
      - FIFO non-empty: reload, pop, stay in SEND, idx=0, no bubble. Back-to-back words give N*k consecutive valid beats.
      - Otherwise: go to IDLE.
- m_ready is ignored while m_valid=0.
- valid_in held high for several cycles pushes one word per cycle while in_ready=1. The sorter pulses for one cycle, but repeated pushes are legal.

Decomposition:
- Shared package sort_pkg:
  - N_ELEM=8, ELEM_W=8
  - typedef elem_t (logic [ELEM_W-1:0])
  - typedef word_t (logic [0:N_ELEM*ELEM_W-1])
  - FSM state enum {S_IDLE, S_SEND}
- One natural sub-module: sort_word_fifo.
  - Parameterised sync FIFO with push/pop/full/empty/count.
  - Instantiated once; the serializer FSM and shift register stay in the top.

Test Plan:
1. Basic order. Push {35,12,24,9,15,44,31,50} sorted, i.e. {9,12,15,24,31,35,44,50}, with m_ready=1 → first beat 2 cycles after push; beats 9,12,15,24,31,35,44,50 on consecutive cycles; m_last only on 50; words_sent=1; m_valid=0 afterwards.
2. Backpressure. Same word, m_ready toggling 1,0,0,1,… → every element emitted exactly once, in order; m_data/m_last stable during stalls; 8 accepted beats total.
3. Back-to-back. Push {0..7} then {7,6,5,4,3,2,1,0}-sorted (= {0..7}) on consecutive cycles, m_ready=1 → 16 consecutive valid beats, no bubble; m_last on beats 8 and 16; words_sent=2.
4. Overflow. DEPTH=2, m_ready=0, push 4 words on consecutive cycles:
   - One word enters SEND (after the IDLE pop), two fill the FIFO, the fourth is dropped.
   - in_ready=0 on the fourth push; overflow=1.
   - Release m_ready → exactly 24 beats.
5. Reset mid-stream. Assert rst after the 3rd beat of a word with another word queued → next cycle m_valid=0, overflow=0, words_sent=0, in_ready=1; no stale beats after rst drops.
6. REVERSE=1. Push {9,12,15,24,31,35,44,50} → beats 50,44,35,31,24,15,12,9; m_last on 9.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and defaults for the sorter result path: element/word types
// and the serializer state encoding.
package sort_pkg;

    localparam int N_ELEM     = 8;
    localparam int ELEM_W     = 8;
    localparam int FIFO_DEPTH = 2;

    typedef logic [ELEM_W-1:0]          elem_t;
    typedef logic [0:N_ELEM*ELEM_W-1]   word_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/sort_word_fifo.sv
// Small synchronous FIFO holding whole packed sorter words. Head is presented
// combinationally on pop_data; DEPTH must be a power of two so pointers wrap.
module sort_word_fifo
    import sort_pkg::*;
#(
    parameter int WIDTH = N_ELEM * ELEM_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sort_result_serializer.sv
// Buffers packed sorted words and streams their elements one per beat over a
// valid/ready interface, flagging the final element of each word with m_last.
module sort_result_serializer
    import sort_pkg::*;
#(
    parameter int N       = N_ELEM,
    parameter int DATA_W  = ELEM_W,
    parameter int DEPTH   = FIFO_DEPTH,
    parameter int REVERSE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N*DATA_W-1:0]   in_data,
    input  logic                  valid_in,
    output logic                  in_ready,
    output logic [DATA_W-1:0]     m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  overflow,
    output logic [15:0]           words_sent
);

    // Handshake: a beat transfers on a rising clk edge where m_valid && m_ready;
    // while m_valid && !m_ready the presented m_data/m_last do not change.
    // Upstream words are taken on valid_in && in_ready, otherwise dropped.

    localparam int WORD_W = N * DATA_W;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam logic [IDX_W-1:0] IDX_PRE_LAST = IDX_W'(N - 2);

    state_t             state;
    logic [WORD_W-1:0]  shreg;
    logic [IDX_W-1:0]   idx;
    logic [WORD_W-1:0]  fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    // Reorders elements at load time so the shift register always emits from its MSB slice.
    function automatic logic [WORD_W-1:0] order_word(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
        r = w;
        if (REVERSE != 0) begin
            for (int k = 0; k < N; k++) begin
                r[k*DATA_W +: DATA_W] = w[(N-1-k)*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction

    assign in_ready = (fifo_count < CNT_W'(DEPTH));
    assign push     = valid_in && in_ready;
    assign pop      = !fifo_empty &&
                      ((state == S_IDLE) || ((state == S_SEND) && m_ready && m_last));
    assign m_data   = shreg[WORD_W-1 -: DATA_W];

    sort_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            shreg      <= '0;
            idx        <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            overflow   <= 1'b0;
            words_sent <= '0;
        end else begin
            if (valid_in && fifo_full) begin
                overflow <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        shreg   <= order_word(fifo_head);
                        idx     <= '0;
                        m_valid <= 1'b1;
                        m_last  <= (N == 1);
                        state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (m_ready) begin
                        shreg <= shreg << DATA_W;
                        if (m_last) begin
                            words_sent <= words_sent + 16'd1;
                            // Reload straight from the FIFO so consecutive words have no gap.
                            if (!fifo_empty) begin
                                shreg  <= order_word(fifo_head);
                                idx    <= '0;
                                m_last <= (N == 1);
                            end else begin
                                m_valid <= 1'b0;
                                m_last  <= 1'b0;
                                state   <= S_IDLE;
                            end
                        end else begin
                            idx    <= idx + 1'b1;
                            m_last <= (idx == IDX_PRE_LAST);
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_result_serializer.sv
// Randomised and directed bench for sort_result_serializer: one instance in
// natural order, one with REVERSE=1, both checked by an expected-beat scoreboard.
module tb_sort_result_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [63:0] in_data0 = '0, in_data1 = '0;
    logic        valid_in0 = 1'b0, valid_in1 = 1'b0;
    logic        in_ready0, in_ready1;
    logic [7:0]  m_data0, m_data1;
    logic        m_valid0, m_valid1;
    logic        m_ready0 = 1'b0, m_ready1 = 1'b0;
    logic        m_last0, m_last1;
    logic        overflow0, overflow1;
    logic [15:0] words_sent0, words_sent1;

    logic [8:0]  exp0_q[$];
    logic [8:0]  exp1_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int beats0 = 0, beats1 = 0;
    int words0 = 0, words1 = 0;
    int run0 = 0, max_run0 = 0;
    int rmode = 0;
    int cyc = 0;

    sort_result_serializer #(.N(8), .DATA_W(8), .DEPTH(2), .REVERSE(0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data0), .valid_in(valid_in0),
        .in_ready(in_ready0), .m_data(m_data0), .m_valid(m_valid0),
        .m_ready(m_ready0), .m_last(m_last0), .overflow(overflow0),
        .words_sent(words_sent0)
    );

    sort_result_serializer #(.N(8), .DATA_W(8), .DEPTH(2), .REVERSE(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data1), .valid_in(valid_in1),
        .in_ready(in_ready1), .m_data(m_data1), .m_valid(m_valid1),
        .m_ready(m_ready1), .m_last(m_last1), .overflow(overflow1),
        .words_sent(words_sent1)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // m_ready driver: 0 always ready, 1 pattern 1,0,0, 2 random, 3 stalled (dut0 only)
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        case (rmode)
            0:       m_ready0 = 1'b1;
            1:       m_ready0 = (cyc % 3 == 0);
            2:       m_ready0 = 1'($urandom_range(0, 1));
            default: m_ready0 = 1'b0;
        endcase
        m_ready1 = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // scoreboard monitors
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            exp0_q.delete();
            run0 = 0;
        end else if (m_valid0) begin
            run0++;
            if (run0 > max_run0) max_run0 = run0;
            if (exp0_q.size() == 0) begin
                check("dut0 unexpected beat", {23'd0, m_last0, m_data0}, 32'h1ff);
            end else begin
                check("dut0 beat {last,data}", {23'd0, m_last0, m_data0}, {23'd0, exp0_q[0]});
                if (m_ready0) begin
                    e = exp0_q.pop_front();
                    beats0++;
                    if (e[8]) words0++;
                end
            end
        end else begin
            run0 = 0;
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            exp1_q.delete();
        end else if (m_valid1) begin
            if (exp1_q.size() == 0) begin
                check("dut1 unexpected beat", {23'd0, m_last1, m_data1}, 32'h1ff);
            end else begin
                check("dut1 beat {last,data}", {23'd0, m_last1, m_data1}, {23'd0, exp1_q[0]});
                if (m_ready1) begin
                    e = exp1_q.pop_front();
                    beats1++;
                    if (e[8]) words1++;
                end
            end
        end
    end

    // reference model: element k is the k-th byte from the MSB; reverse order for dut1
    task automatic enqueue(input bit sel, input logic [63:0] w);
        for (int j = 0; j < 8; j++) begin
            int k;
            logic [8:0] b;
            k = sel ? 7 - j : j;
            b = {(j == 7), w[63 - 8*k -: 8]};
            if (!sel) exp0_q.push_back(b);
            else      exp1_q.push_back(b);
        end
    endtask

    function automatic logic [63:0] rand_word();
        logic [7:0]  q[$];
        logic [63:0] w;
        for (int k = 0; k < 8; k++) q.push_back(8'($urandom_range(0, 255)));
        q.sort();
        w = '0;
        for (int k = 0; k < 8; k++) w[63 - 8*k -: 8] = q[k];
        return w;
    endfunction

    // driver: called at posedge+1, presents the word for one cycle
    task automatic push_word(input bit sel, input logic [63:0] w, input bit exp_acc);
        if (!sel) begin
            in_data0  = w;
            valid_in0 = 1'b1;
            check("dut0 in_ready at push", {31'd0, in_ready0}, {31'd0, exp_acc});
        end else begin
            in_data1  = w;
            valid_in1 = 1'b1;
            check("dut1 in_ready at push", {31'd0, in_ready1}, {31'd0, exp_acc});
        end
        if (exp_acc) enqueue(sel, w);
        @(posedge clk); #1;
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        while (i < 3000 && !(exp0_q.size() == 0 && exp1_q.size() == 0 && !m_valid0 && !m_valid1)) begin
            @(negedge clk);
            i++;
        end
        check({"drain timeout ", name}, {31'd0, (i >= 3000)}, 32'd0);
    endtask

    initial begin
        int b0;
        int n0, n1;
        logic [63:0] w;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset m_valid",    {31'd0, m_valid0},  32'd0);
        check("reset m_last",     {31'd0, m_last0},   32'd0);
        check("reset m_data",     {24'd0, m_data0},   32'd0);
        check("reset overflow",   {31'd0, overflow0}, 32'd0);
        check("reset words_sent", {16'd0, words_sent0}, 32'd0);
        check("reset in_ready",   {31'd0, in_ready0}, 32'd1);

        // basic order and latency
        @(posedge clk); #1;
        rmode = 0;
        max_run0 = 0;
        push_word(0, 64'h090C0F181F232C32, 1'b1);
        @(negedge clk);
        check("basic m_valid 1 cycle after push", {31'd0, m_valid0}, 32'd0);
        @(negedge clk);
        check("basic m_valid 2 cycles after push", {31'd0, m_valid0}, 32'd1);
        check("basic first element", {24'd0, m_data0}, 32'd9);
        wait_idle("basic");
        check("basic consecutive beats", max_run0, 32'd8);
        check("basic words_sent", {16'd0, words_sent0}, 32'(words0 % 65536));
        check("basic words model", words0, 32'd1);

        // reverse order on dut1
        @(posedge clk); #1;
        push_word(1, 64'h090C0F181F232C32, 1'b1);
        wait_idle("reverse");
        check("reverse words_sent", {16'd0, words_sent1}, 32'd1);

        // backpressure pattern
        b0 = beats0;
        rmode = 1;
        @(posedge clk); #1;
        push_word(0, 64'h090C0F181F232C32, 1'b1);
        wait_idle("backpressure");
        check("backpressure beats", beats0 - b0, 32'd8);
        check("backpressure words_sent", {16'd0, words_sent0}, 32'd2);

        // back-to-back words
        rmode = 0;
        @(posedge clk); #1;
        max_run0 = 0;
        push_word(0, 64'h0001020304050607, 1'b1);
        push_word(0, 64'h0001020304050607, 1'b1);
        wait_idle("back2back");
        check("back2back consecutive beats", max_run0, 32'd16);
        check("back2back words_sent", {16'd0, words_sent0}, 32'd4);

        // overflow with stalled sink
        rmode = 3;
        @(posedge clk); #1;
        b0 = beats0;
        push_word(0, rand_word(), 1'b1);
        push_word(0, rand_word(), 1'b1);
        push_word(0, rand_word(), 1'b1);
        push_word(0, rand_word(), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("overflow flag", {31'd0, overflow0}, 32'd1);
        check("overflow in_ready while full", {31'd0, in_ready0}, 32'd0);
        rmode = 0;
        wait_idle("overflow");
        check("overflow beats after release", beats0 - b0, 32'd24);
        check("overflow words_sent", {16'd0, words_sent0}, 32'(words0 % 65536));

        // randomised traffic on both instances
        rmode = 2;
        @(posedge clk); #1;
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 900; c++) begin
            valid_in0 = 1'b0;
            valid_in1 = 1'b0;
            if (n0 < 25 && in_ready0 && $urandom_range(0, 2) == 0) begin
                w = rand_word();
                in_data0 = w; valid_in0 = 1'b1; enqueue(0, w); n0++;
            end
            if (n1 < 25 && in_ready1 && $urandom_range(0, 2) == 0) begin
                w = rand_word();
                in_data1 = w; valid_in1 = 1'b1; enqueue(1, w); n1++;
            end
            @(posedge clk); #1;
        end
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
        rmode = 0;
        wait_idle("random");
        check("random dut0 words_sent", {16'd0, words_sent0}, 32'(words0 % 65536));
        check("random dut1 words_sent", {16'd0, words_sent1}, 32'(words1 % 65536));
        check("random dut0 overflow sticky", {31'd0, overflow0}, 32'd1);
        check("random dut1 overflow", {31'd0, overflow1}, 32'd0);

        // reset mid-stream with a word queued
        @(posedge clk); #1;
        b0 = beats0;
        push_word(0, rand_word(), 1'b1);
        push_word(0, rand_word(), 1'b1);
        for (int i = 0; i < 50 && beats0 != b0 + 3; i++) begin
            @(posedge clk); #1;
        end
        check("midstream reached 3 beats", beats0 - b0, 32'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        words0 = 0;
        b0 = beats0;
        @(negedge clk);
        check("midreset m_valid",    {31'd0, m_valid0},  32'd0);
        check("midreset overflow",   {31'd0, overflow0}, 32'd0);
        check("midreset words_sent", {16'd0, words_sent0}, 32'd0);
        check("midreset in_ready",   {31'd0, in_ready0}, 32'd1);
        repeat (30) @(negedge clk);
        check("midreset no stale beats", beats0 - b0, 32'd0);
        check("midreset idle m_valid", {31'd0, m_valid0}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
